// File: rtl/conv_window_gen_if.sv
// Window-generator bus: pixel stream in, 3x3 window plus start/done handshake out.
// Latency: none, wires only.
// Backpressure: pix_ready from the generator stalls the pixel source; ready_dot releases a window.
interface conv_window_gen_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] pix_in;
   logic              pix_valid;
   logic              pix_ready;
   logic [DATA_W-1:0] img_bit_0, img_bit_1, img_bit_2;
   logic [DATA_W-1:0] img_bit_3, img_bit_4, img_bit_5;
   logic [DATA_W-1:0] img_bit_6, img_bit_7, img_bit_8;
   logic              initate;
   logic              ready_dot;
   logic              frame_done;

   // master: the window generator itself
   modport master (
      input  pix_in, pix_valid, ready_dot,
      output pix_ready, initate, frame_done,
      output img_bit_0, img_bit_1, img_bit_2, img_bit_3, img_bit_4,
      output img_bit_5, img_bit_6, img_bit_7, img_bit_8
   );

   // slave: pixel source plus dot-product stage
   modport slave (
      output pix_in, pix_valid, ready_dot,
      input  pix_ready, initate, frame_done,
      input  img_bit_0, img_bit_1, img_bit_2, img_bit_3, img_bit_4,
      input  img_bit_5, img_bit_6, img_bit_7, img_bit_8
   );
endinterface

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator over a raster frame, two line buffers plus a column history.
// Latency: a window is on img_bit_* with initate high one cycle after its bottom-right pixel is accepted.
// Backpressure: pix_ready low while a window is outstanding; it is held until ready_dot (ignored on its first cycle).
module conv_window_gen #(
   parameter int DATA_W = 32,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28
) (
   input  logic             clk,
   input  logic             rst,
   conv_window_gen_if.master win_if
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H + 1);

   typedef enum logic [1:0] {ACCEPT, BUSY, DONE} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           col_q, col_d;
   logic [RW-1:0]           row_q, row_d;
   logic                    first_q, first_d;   // first cycle of BUSY: ready_dot not trusted yet
   logic                    last_q, last_d;     // outstanding window is the last one of the frame
   logic [8:0][DATA_W-1:0]  win_q, win_d;       // presented window, row-major
   logic [2:0][DATA_W-1:0]  h1_q, h1_d;         // column c-1 of current row band, [0]=top
   logic [2:0][DATA_W-1:0]  h2_q, h2_d;         // column c-2 of current row band, [0]=top

   logic [DATA_W-1:0]       lb1 [IMG_W];        // pixels of row-1
   logic [DATA_W-1:0]       lb2 [IMG_W];        // pixels of row-2

   logic                    pix_ready;
   logic                    accept;
   logic                    col_wrap;
   logic                    win_ok;
   logic                    last_pix;
   logic [2:0][DATA_W-1:0]  new_col;

   assign pix_ready = (state_q == ACCEPT) && !rst;
   assign accept    = pix_ready && win_if.pix_valid;
   assign col_wrap  = (int'(col_q) == IMG_W - 1);
   assign win_ok    = (int'(row_q) >= 2) && (int'(col_q) >= 2);
   assign last_pix  = col_wrap && (int'(row_q) == IMG_H - 1);

   assign new_col[0] = lb2[col_q];
   assign new_col[1] = lb1[col_q];
   assign new_col[2] = win_if.pix_in;

   // Line buffers: age the column by one row and store the new pixel.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb2[col_q] <= lb1[col_q];
         lb1[col_q] <= win_if.pix_in;
      end
   end

   // Next-state: pixel acceptance, window capture and window handshake.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      first_d = 1'b0;
      last_d  = last_q;
      win_d   = win_q;
      h1_d    = h1_q;
      h2_d    = h2_q;
      case (state_q)
         ACCEPT: begin
            if (accept) begin
               if (col_wrap) begin
                  // A new row starts with no horizontal history.
                  col_d = '0;
                  row_d = row_q + 1'b1;
                  h1_d  = '0;
                  h2_d  = '0;
               end else begin
                  col_d = col_q + 1'b1;
                  h1_d  = new_col;
                  h2_d  = h1_q;
               end
               if (win_ok) begin
                  for (int k = 0; k < 3; k++) begin
                     win_d[3*k]     = h2_q[k];
                     win_d[3*k + 1] = h1_q[k];
                     win_d[3*k + 2] = new_col[k];
                  end
                  state_d = BUSY;
                  first_d = 1'b1;
                  last_d  = last_pix;
               end
            end
         end
         BUSY: begin
            if (!first_q && win_if.ready_dot) begin
               state_d = last_q ? DONE : ACCEPT;
            end
         end
         DONE: begin
            state_d = ACCEPT;
            col_d   = '0;
            row_d   = '0;
         end
         default: state_d = ACCEPT;
      endcase
   end

   // State registers with asynchronous reset to the start-of-frame state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ACCEPT;
         col_q   <= '0;
         row_q   <= '0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         win_q   <= '0;
         h1_q    <= '0;
         h2_q    <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         first_q <= first_d;
         last_q  <= last_d;
         win_q   <= win_d;
         h1_q    <= h1_d;
         h2_q    <= h2_d;
      end
   end

   assign win_if.pix_ready  = pix_ready;
   assign win_if.initate    = (state_q == BUSY);
   assign win_if.frame_done = (state_q == DONE);
   assign win_if.img_bit_0  = win_q[0];
   assign win_if.img_bit_1  = win_q[1];
   assign win_if.img_bit_2  = win_q[2];
   assign win_if.img_bit_3  = win_q[3];
   assign win_if.img_bit_4  = win_q[4];
   assign win_if.img_bit_5  = win_q[5];
   assign win_if.img_bit_6  = win_q[6];
   assign win_if.img_bit_7  = win_q[7];
   assign win_if.img_bit_8  = win_q[8];
endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: 4x4 and 5x3 instances, table vectors, reset sequence, random frames.
// Windows are predicted from the frame contents by direct index arithmetic.
// ready_dot timing and pix_valid gaps are varied to exercise backpressure and the stale-level guard.
module tb_conv_window_gen;
   localparam int DW = 32;
   typedef logic [8:0][DW-1:0] win_t;

   typedef struct {
      int   id;
      bit   s;
      int   w;
      int   h;
      int   base;
      int   rdm;
      int   rdd;
      int   vm;
      int   nwin;
      win_t first;
      win_t last;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   conv_window_gen_if #(.DATA_W(DW)) if44 ();
   conv_window_gen_if #(.DATA_W(DW)) if53 ();

   conv_window_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut44 (.clk(clk), .rst(rst), .win_if(if44));
   conv_window_gen #(.DATA_W(DW), .IMG_W(5), .IMG_H(3)) dut53 (.clk(clk), .rst(rst), .win_if(if53));

   logic          sel;
   logic [DW-1:0] pix_in;
   logic          pix_valid;
   logic          ready_dot;

   assign if44.pix_in    = pix_in;
   assign if53.pix_in    = pix_in;
   assign if44.pix_valid = pix_valid & ~sel;
   assign if53.pix_valid = pix_valid & sel;
   assign if44.ready_dot = ready_dot & ~sel;
   assign if53.ready_dot = ready_dot & sel;

   win_t m_img;
   logic m_pix_ready, m_initate, m_frame_done;

   always_comb begin
      if (sel) begin
         m_img = {if53.img_bit_8, if53.img_bit_7, if53.img_bit_6, if53.img_bit_5, if53.img_bit_4,
                  if53.img_bit_3, if53.img_bit_2, if53.img_bit_1, if53.img_bit_0};
         m_pix_ready  = if53.pix_ready;
         m_initate    = if53.initate;
         m_frame_done = if53.frame_done;
      end else begin
         m_img = {if44.img_bit_8, if44.img_bit_7, if44.img_bit_6, if44.img_bit_5, if44.img_bit_4,
                  if44.img_bit_3, if44.img_bit_2, if44.img_bit_1, if44.img_bit_0};
         m_pix_ready  = if44.pix_ready;
         m_initate    = if44.initate;
         m_frame_done = if44.frame_done;
      end
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [319:0] got, input logic [319:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic win_t mkwin(input int a0, input int a1, input int a2, input int a3, input int a4,
                                  input int a5, input int a6, input int a7, input int a8);
      win_t x;
      x[0] = DW'(a0); x[1] = DW'(a1); x[2] = DW'(a2);
      x[3] = DW'(a3); x[4] = DW'(a4); x[5] = DW'(a5);
      x[6] = DW'(a6); x[7] = DW'(a7); x[8] = DW'(a8);
      return x;
   endfunction

   // Reference model: the frame as a flat raster array, windows by index arithmetic.
   logic [DW-1:0] frame_pix[$];
   win_t          exp_q[$];
   win_t          got_q[$];
   int            fd_cnt = 0;

   function automatic win_t model_win(input int w, input int r, input int c);
      win_t x;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            x[i*3 + j] = frame_pix[(r - 2 + i) * w + (c - 2 + j)];
      return x;
   endfunction

   // Dot-product stage stand-in: ready_dot after a chosen delay, constant, or random.
   int rd_mode = 0;
   int rd_delay = 2;
   int vmode = 0;
   int busy_cnt = 0;
   int cur_delay = 0;
   int exp_hold = 2;

   always @(negedge clk) begin
      if (rst || !m_initate) begin
         busy_cnt  = 0;
         ready_dot = (rd_mode == 1) ? 1'b1 : (rd_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
         busy_cnt++;
         if (busy_cnt == 1) begin
            cur_delay = (rd_mode == 2) ? int'($urandom_range(0, 6)) : (rd_mode == 1) ? 0 : rd_delay;
            exp_hold  = (cur_delay + 1 < 2) ? 2 : cur_delay + 1;
         end
         ready_dot = (busy_cnt > cur_delay);
      end
   end

   // Window monitor: capture on initate rise, hold stable with pix_ready low, hold length.
   int   hold = 0;
   logic prev_init = 1'b0;
   win_t cap;

   always @(negedge clk) begin
      if (rst) begin
         prev_init = 1'b0;
         hold      = 0;
      end else begin
         if (m_initate && !prev_init) begin
            cap = m_img;
            got_q.push_back(m_img);
            hold = 1;
            chk("busy_pix_ready", 320'(m_pix_ready), 320'(0));
         end else if (m_initate) begin
            hold++;
            chk("busy_stable", 320'({m_pix_ready, m_img}), 320'({1'b0, cap}));
         end else if (prev_init) begin
            chk("initate_hold", 320'(hold), 320'(exp_hold));
         end
         if (m_frame_done) fd_cnt++;
         prev_init = m_initate;
      end
   end

   task automatic send_frame();
      int i   = 0;
      int cyc = 0;
      bit ph  = 1'b0;
      while (i < frame_pix.size() && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         case (vmode)
            0:       ph = 1'b1;
            1:       ph = !ph;
            default: ph = 1'($urandom_range(0, 1));
         endcase
         pix_valid = ph;
         pix_in    = ph ? frame_pix[i] : DW'($urandom);
         if (ph && m_pix_ready) i++;
      end
      @(negedge clk);
      pix_valid = 1'b0;
      chk("send_all_pixels", 320'(i), 320'(frame_pix.size()));
   endtask

   task automatic run_frame(input int id, input bit s, input int w, input int h);
      int t;
      sel = s;
      exp_q.delete();
      got_q.delete();
      fd_cnt = 0;
      for (int r = 2; r < h; r++)
         for (int c = 2; c < w; c++)
            exp_q.push_back(model_win(w, r, c));
      send_frame();
      t = 0;
      while (fd_cnt == 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      chk($sformatf("T%0d_frame_done", id), 320'(fd_cnt), 320'(1));
      chk($sformatf("T%0d_nwin", id), 320'(got_q.size()), 320'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
         chk($sformatf("T%0d_win%0d", id, k), 320'(got_q[k]), 320'(exp_q[k]));
   endtask

   task automatic fill_seq(input int base, input int n);
      frame_pix.delete();
      for (int i = 0; i < n; i++) frame_pix.push_back(DW'(base + i));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_img44"}, 320'({if44.img_bit_8, if44.img_bit_7, if44.img_bit_6, if44.img_bit_5,
          if44.img_bit_4, if44.img_bit_3, if44.img_bit_2, if44.img_bit_1, if44.img_bit_0}), 320'(0));
      chk({tag, "_ctl44"}, 320'({if44.pix_ready, if44.initate, if44.frame_done}), 320'(0));
      chk({tag, "_ctl53"}, 320'({if53.pix_ready, if53.initate, if53.frame_done}), 320'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t vt[5];

   initial begin
      vt[0] = '{1, 1'b0, 4, 4, 0, 0, 2, 0, 4,
                mkwin(0, 1, 2, 4, 5, 6, 8, 9, 10), mkwin(5, 6, 7, 9, 10, 11, 13, 14, 15)};
      vt[1] = '{2, 1'b0, 4, 4, 0, 0, 20, 0, 4,
                mkwin(0, 1, 2, 4, 5, 6, 8, 9, 10), mkwin(5, 6, 7, 9, 10, 11, 13, 14, 15)};
      vt[2] = '{3, 1'b0, 4, 4, 0, 1, 0, 0, 4,
                mkwin(0, 1, 2, 4, 5, 6, 8, 9, 10), mkwin(5, 6, 7, 9, 10, 11, 13, 14, 15)};
      vt[3] = '{6, 1'b0, 4, 4, 100, 0, 2, 0, 4,
                mkwin(100, 101, 102, 104, 105, 106, 108, 109, 110),
                mkwin(105, 106, 107, 109, 110, 111, 113, 114, 115)};
      vt[4] = '{4, 1'b1, 5, 3, 0, 0, 2, 1, 3,
                mkwin(0, 1, 2, 5, 6, 7, 10, 11, 12), mkwin(2, 3, 4, 7, 8, 9, 12, 13, 14)};

      rst       = 1'b1;
      sel       = 1'b0;
      pix_in    = '0;
      pix_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      #2 rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 320'({if44.pix_ready, if53.pix_ready}), 320'(2'b11));

      // Table vectors; T3 then T6 run back to back on the 4x4 instance without reset.
      for (int v = 0; v < 5; v++) begin
         fill_seq(vt[v].base, vt[v].w * vt[v].h);
         rd_mode  = vt[v].rdm;
         rd_delay = vt[v].rdd;
         vmode    = vt[v].vm;
         run_frame(vt[v].id, vt[v].s, vt[v].w, vt[v].h);
         chk($sformatf("T%0d_table_nwin", vt[v].id), 320'(got_q.size()), 320'(vt[v].nwin));
         chk($sformatf("T%0d_table_first", vt[v].id),
             320'((got_q.size() > 0) ? got_q[0] : win_t'('0)), 320'(vt[v].first));
         chk($sformatf("T%0d_table_last", vt[v].id),
             320'((got_q.size() > 0) ? got_q[got_q.size() - 1] : win_t'('0)), 320'(vt[v].last));
      end

      // T5: reset while the second window of a frame is outstanding, then a clean frame.
      sel      = 1'b0;
      rd_mode  = 0;
      rd_delay = 20;
      vmode    = 0;
      fill_seq(0, 12);
      send_frame();
      repeat (3) @(negedge clk);
      chk("T5_in_busy", 320'(m_initate), 320'(1));
      chk("T5_busy_win", 320'(m_img), 320'(mkwin(1, 2, 3, 5, 6, 7, 9, 10, 11)));
      #2 rst = 1'b1;
      #1;
      chk_reset_outputs("T5_rst");
      @(negedge clk);
      chk_reset_outputs("T5_rst_hold");
      #2 rst = 1'b0;
      rd_delay = 2;
      fill_seq(0, 16);
      run_frame(5, 1'b0, 4, 4);
      chk("T5_first", 320'((got_q.size() > 0) ? got_q[0] : win_t'('0)),
          320'(mkwin(0, 1, 2, 4, 5, 6, 8, 9, 10)));

      // Random frames: random data, random pix_valid gaps, random or constant ready_dot.
      for (int n = 0; n < 8; n++) begin
         bit s;
         int w;
         int h;
         s = n[0];
         w = s ? 5 : 4;
         h = s ? 3 : 4;
         frame_pix.delete();
         for (int i = 0; i < w * h; i++) frame_pix.push_back(DW'($urandom));
         rd_mode = (n % 3 == 2) ? 1 : 2;
         vmode   = 2;
         run_frame(10 + n, s, w, h);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
